// File: rtl/idma_resi_raddr_mc_gen.sv
`default_nettype none
// ============================================================================
// Module   : idma_resi_raddr_mc_gen
// Brief    : Multi-channel residual read-address generator. Issues one read
//            address per enabled channel per loop, in ascending channel
//            order. Each channel has its own base and stride. Supports a
//            channel mask, last/done signalling and abort.
// Revision : 1.0  initial multi-channel release
// ============================================================================
module idma_resi_raddr_mc_gen #(
    parameter int  CH_NUM = 4,
    parameter int  AW     = 32,
    parameter int  GW     = 16,
    parameter int  LW     = 16,
    localparam int CW     = $clog2(CH_NUM)
) (
    input  logic                 cclk,
    input  logic                 rst_n,
    input  logic                 cfg_start,
    input  logic                 cfg_abort,
    input  logic [CH_NUM-1:0]    cfg_ch_en,
    input  logic [CH_NUM*AW-1:0] cfg_base,
    input  logic [CH_NUM*GW-1:0] cfg_gap,
    input  logic [LW-1:0]        cfg_loop_num,
    input  logic                 afifo_full,
    output logic                 req_vld,
    output logic [AW-1:0]        req_addr,
    output logic [CW-1:0]        req_ch,
    output logic                 req_last,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t              r_state;
    logic [CH_NUM-1:0]   r_ch_en;
    logic [GW-1:0]       r_gap  [CH_NUM];
    logic [AW-1:0]       r_addr [CH_NUM];
    logic [LW-1:0]       r_loop_num;
    logic [LW-1:0]       r_loop_cnt;
    logic [CW-1:0]       r_cur_ch;
    logic                r_done;

    logic [AW-1:0]       w_base [CH_NUM];
    logic [GW-1:0]       w_gap  [CH_NUM];
    logic [CW-1:0]       w_hi_ch;
    logic [CW-1:0]       w_next_ch;
    logic                w_run;
    logic                w_at_hi;
    logic                w_last_loop;

    // Lowest set bit of a channel mask (0 when the mask is empty).
    function automatic logic [CW-1:0] f_lowest(input logic [CH_NUM-1:0] m);
        logic [CW-1:0] res;
        res = '0;
        for (int i = CH_NUM - 1; i >= 0; i--) begin
            if (m[i]) res = CW'(i);
        end
        return res;
    endfunction

    // Highest set bit of a channel mask (0 when the mask is empty).
    function automatic logic [CW-1:0] f_highest(input logic [CH_NUM-1:0] m);
        logic [CW-1:0] res;
        res = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (m[i]) res = CW'(i);
        end
        return res;
    endfunction

    // Next enabled channel above cur, wrapping to the lowest enabled one.
    function automatic logic [CW-1:0] f_next(input logic [CH_NUM-1:0] m,
                                             input logic [CW-1:0]     cur);
        logic [CW-1:0] res;
        res = f_lowest(m);
        for (int i = CH_NUM - 1; i >= 0; i--) begin
            if (m[i] && (CW'(i) > cur)) res = CW'(i);
        end
        return res;
    endfunction

    // Split the flat configuration buses into per-channel views.
    generate
        for (genvar g = 0; g < CH_NUM; g++) begin : g_unpack
            assign w_base[g] = cfg_base[g*AW +: AW];
            assign w_gap[g]  = cfg_gap[g*GW +: GW];
        end
    endgenerate

    assign w_run       = (r_state == S_RUN);
    assign w_hi_ch     = f_highest(r_ch_en);
    assign w_next_ch   = f_next(r_ch_en, r_cur_ch);
    assign w_at_hi     = (r_cur_ch == w_hi_ch);
    assign w_last_loop = (r_loop_cnt == (r_loop_num - LW'(1)));

    // Request outputs are combinational from state and the two flow inputs.
    assign req_vld  = w_run & ~afifo_full & ~cfg_abort;
    assign req_addr = w_run ? r_addr[r_cur_ch] : '0;
    assign req_ch   = w_run ? r_cur_ch : '0;
    assign req_last = req_vld & w_last_loop & w_at_hi;
    assign busy     = w_run;
    assign done     = r_done;

    // Control FSM and per-channel address walk; abort overrides everything.
    always_ff @(posedge cclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_ch_en    <= '0;
            r_loop_num <= '0;
            r_loop_cnt <= '0;
            r_cur_ch   <= '0;
            r_done     <= 1'b0;
            for (int i = 0; i < CH_NUM; i++) begin
                r_addr[i] <= '0;
                r_gap[i]  <= '0;
            end
        end else begin
            r_done <= 1'b0;
            if (cfg_abort) begin
                r_state    <= S_IDLE;
                r_loop_cnt <= '0;
                r_cur_ch   <= '0;
                for (int i = 0; i < CH_NUM; i++) begin
                    r_addr[i] <= '0;
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (cfg_start) begin
                            if ((cfg_ch_en != '0) && (cfg_loop_num != '0)) begin
                                r_state    <= S_RUN;
                                r_ch_en    <= cfg_ch_en;
                                r_loop_num <= cfg_loop_num;
                                r_loop_cnt <= '0;
                                r_cur_ch   <= f_lowest(cfg_ch_en);
                                for (int i = 0; i < CH_NUM; i++) begin
                                    r_addr[i] <= w_base[i];
                                    r_gap[i]  <= w_gap[i];
                                end
                            end else begin
                                // Nothing to issue: finish immediately.
                                r_done <= 1'b1;
                            end
                        end
                    end
                    S_RUN: begin
                        if (req_vld) begin
                            r_addr[r_cur_ch] <= r_addr[r_cur_ch] + AW'(r_gap[r_cur_ch]);
                            r_cur_ch         <= w_next_ch;
                            if (w_at_hi) begin
                                r_loop_cnt <= r_loop_cnt + LW'(1);
                            end
                            if (req_last) begin
                                r_state <= S_IDLE;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
